// File: rtl/blink_sequencer.sv
// -----------------------------------------------------------------------------
// blink_sequencer
//   Drives an LED through a number of on/off blinks. A rising edge on start
//   samples the phase lengths and the blink count, then the FSM alternates
//   ON and OFF phases. With a nonzero count it stops after that many full
//   blinks and pulses done. With a zero count it runs until stop, reset or a
//   new start. Every output comes straight from a flop.
//
// Ports
//   hwclk        system clock (rising edge)
//   rst          synchronous active-high reset
//   start        level; rising edge requests (or restarts) a sequence
//   stop         level; forces IDLE, wins over a simultaneous start edge
//   on_ticks     on-phase length in cycles (0 behaves as 1)
//   off_ticks    off-phase length in cycles (0 behaves as 1)
//   blink_count  number of full blinks, 0 = continuous
//   led          LED drive, LED_ACTIVE during on-phases
//   busy         high while in ON or OFF
//   done         one-cycle pulse on normal completion
//   blinks_done  completed full blinks of the current / last sequence
// -----------------------------------------------------------------------------
module blink_sequencer #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NUM_W      = 8,
  parameter bit          LED_ACTIVE = 1'b1
) (
  input  logic             hwclk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] on_ticks,
  input  logic [CNT_W-1:0] off_ticks,
  input  logic [NUM_W-1:0] blink_count,
  output logic             led,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] blinks_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t             state_q,       state_d;
  logic               start_q,       start_d;
  logic [CNT_W-1:0]   timer_q,       timer_d;
  logic [CNT_W-1:0]   on_len_q,      on_len_d;
  logic [CNT_W-1:0]   off_len_q,     off_len_d;
  logic [NUM_W-1:0]   num_q,         num_d;
  logic [NUM_W-1:0]   blinks_q,      blinks_d;
  logic               led_q,         led_d;
  logic               busy_q,        busy_d;
  logic               done_q,        done_d;

  logic               start_rise;
  logic [CNT_W-1:0]   on_last;
  logic [CNT_W-1:0]   off_last;
  logic [NUM_W-1:0]   blinks_inc;

  assign start_rise = start & ~start_q;

  // Last timer value of each phase; a programmed length of 0 behaves as 1.
  assign on_last    = (on_len_q  == '0) ? '0 : on_len_q  - CNT_W'(1);
  assign off_last   = (off_len_q == '0) ? '0 : off_len_q - CNT_W'(1);
  assign blinks_inc = blinks_q + NUM_W'(1);

  always_comb begin
    state_d   = state_q;
    start_d   = start;
    timer_d   = timer_q;
    on_len_d  = on_len_q;
    off_len_d = off_len_q;
    num_d     = num_q;
    blinks_d  = blinks_q;
    done_d    = 1'b0;

    if (stop) begin
      // Abort: blinks_done keeps the value reached so far.
      state_d = S_IDLE;
      timer_d = '0;
    end else if (start_rise) begin
      // A new start restarts from any state and suppresses a coincident done.
      state_d   = S_ON;
      timer_d   = '0;
      on_len_d  = on_ticks;
      off_len_d = off_ticks;
      num_d     = blink_count;
      blinks_d  = '0;
    end else begin
      unique case (state_q)
        S_ON: begin
          if (timer_q == on_last) begin
            timer_d = '0;
            state_d = S_OFF;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        S_OFF: begin
          if (timer_q == off_last) begin
            timer_d  = '0;
            blinks_d = blinks_inc;
            if ((num_q != '0) && (blinks_inc == num_q)) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ON;
            end
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end

    // Outputs follow the next state so that they line up with it in time.
    led_d  = (state_d == S_ON) ? LED_ACTIVE : ~LED_ACTIVE;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      start_q   <= start;   // start held through reset must not count as an edge
      timer_q   <= '0;
      on_len_q  <= '0;
      off_len_q <= '0;
      num_q     <= '0;
      blinks_q  <= '0;
      led_q     <= ~LED_ACTIVE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      timer_q   <= timer_d;
      on_len_q  <= on_len_d;
      off_len_q <= off_len_d;
      num_q     <= num_d;
      blinks_q  <= blinks_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign led         = led_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign blinks_done = blinks_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// -----------------------------------------------------------------------------
// tb_blink_sequencer
//   Two instances share one stimulus stream: u_a (NUM_W=4, LED active high)
//   and u_b (NUM_W=2, LED active low). A reference model describes each
//   sequence by its start point and elapsed cycle count k. LED phase, blink
//   count and completion are derived arithmetically from k. Directed steps
//   come first, followed by a randomized stretch.
// -----------------------------------------------------------------------------
module tb_blink_sequencer;
  localparam int CW = 16;

  logic          hwclk = 1'b0;
  logic          rst, start, stop;
  logic [CW-1:0] on_ticks, off_ticks;
  logic [3:0]    cnt;
  logic          led_a, busy_a, done_a, led_b, busy_b, done_b;
  logic [3:0]    bd_a;
  logic [1:0]    bd_b;

  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  always #5 hwclk = ~hwclk;

  blink_sequencer #(.CNT_W(CW), .NUM_W(4), .LED_ACTIVE(1'b1)) u_a (
    .hwclk(hwclk), .rst(rst), .start(start), .stop(stop),
    .on_ticks(on_ticks), .off_ticks(off_ticks), .blink_count(cnt),
    .led(led_a), .busy(busy_a), .done(done_a), .blinks_done(bd_a));

  blink_sequencer #(.CNT_W(CW), .NUM_W(2), .LED_ACTIVE(1'b0)) u_b (
    .hwclk(hwclk), .rst(rst), .start(start), .stop(stop),
    .on_ticks(on_ticks), .off_ticks(off_ticks), .blink_count(cnt[1:0]),
    .led(led_b), .busy(busy_b), .done(done_b), .blinks_done(bd_b));

  // Reference model state, one entry per instance.
  bit     m_act  [2];
  longint m_k    [2];
  longint m_a    [2];
  longint m_b    [2];
  longint m_n    [2];
  longint m_held [2];
  bit     m_done [2];
  bit     prev_start;

  function automatic longint mask(int i);
    return (i == 0) ? 64'd15 : 64'd3;
  endfunction

  function automatic longint m_blinks(int i);
    return (m_k[i] / (m_a[i] + m_b[i])) & mask(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit rise;
    rise = start & ~prev_start;
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (rst) begin
        m_act[i]  = 1'b0;
        m_held[i] = 0;
      end else if (stop) begin
        if (m_act[i]) m_held[i] = m_blinks(i);
        m_act[i] = 1'b0;
      end else if (rise) begin
        m_act[i] = 1'b1;
        m_k[i]   = 0;
        m_a[i]   = (on_ticks  == 0) ? 1 : longint'(on_ticks);
        m_b[i]   = (off_ticks == 0) ? 1 : longint'(off_ticks);
        m_n[i]   = longint'(cnt) & mask(i);
      end else if (m_act[i]) begin
        m_k[i]++;
        if (m_n[i] != 0 && m_k[i] >= m_n[i] * (m_a[i] + m_b[i])) begin
          m_act[i]  = 1'b0;
          m_held[i] = m_n[i];
          m_done[i] = 1'b1;
        end
      end
    end
    prev_start = start;
  endtask

  task automatic check_all();
    logic          act_lvl, e_led, e_busy;
    logic [31:0]   e_bd;
    for (int i = 0; i < 2; i++) begin
      act_lvl = (i == 0) ? 1'b1 : 1'b0;
      if (m_act[i]) begin
        e_led  = ((m_k[i] % (m_a[i] + m_b[i])) < m_a[i]) ? act_lvl : ~act_lvl;
        e_busy = 1'b1;
        e_bd   = 32'(m_blinks(i));
      end else begin
        e_led  = ~act_lvl;
        e_busy = 1'b0;
        e_bd   = 32'(m_held[i]);
      end
      if (i == 0) begin
        chk("a_led",  32'(led_a),  32'(e_led));
        chk("a_busy", 32'(busy_a), 32'(e_busy));
        chk("a_done", 32'(done_a), 32'(m_done[0]));
        chk("a_bd",   32'(bd_a),   e_bd);
      end else begin
        chk("b_led",  32'(led_b),  32'(e_led));
        chk("b_busy", 32'(busy_b), 32'(e_busy));
        chk("b_done", 32'(done_b), 32'(m_done[1]));
        chk("b_bd",   32'(bd_b),   e_bd);
      end
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge hwclk);
      model_step();
      #1;
      check_all();
    end
  endtask

  initial begin
    logic [9:0] pat;
    logic [1:0] wrap [5];
    logic [4:0] pol;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    on_ticks = '0; off_ticks = '0; cnt = '0;
    prev_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_a[i] = 1; m_b[i] = 1;
      m_n[i] = 0; m_held[i] = 0; m_done[i] = 0;
    end
    cyc(2);
    chk("rst_led_a", 32'(led_a), 32'd0);
    chk("rst_led_b", 32'(led_b), 32'd1);
    chk("rst_bd_a",  32'(bd_a),  32'd0);
    rst = 1'b0;
    cyc();

    // Basic run: on=3, off=2, two blinks.
    on_ticks = 3; off_ticks = 2; cnt = 2;
    start = 1'b1; cyc();
    pat = 10'b1110011100;
    for (int i = 0; i < 10; i++) begin
      chk("basic_led", 32'(led_a), 32'(pat[9-i]));
      chk("basic_nodone", 32'(done_a), 32'd0);
      cyc();
    end
    chk("basic_done", 32'(done_a), 32'd1);
    chk("basic_bd",   32'(bd_a),   32'd2);
    cyc();
    chk("basic_done_low", 32'(done_a), 32'd0);
    chk("basic_busy_low", 32'(busy_a), 32'd0);
    start = 1'b0; cyc();

    // Zero lengths behave as one cycle each.
    on_ticks = 0; off_ticks = 0; cnt = 3;
    start = 1'b1; cyc();
    for (int i = 0; i < 6; i++) begin
      chk("zero_led", 32'(led_a), 32'((i % 2) == 0));
      cyc();
    end
    chk("zero_done", 32'(done_a), 32'd1);
    chk("zero_bd",   32'(bd_a),   32'd3);
    start = 1'b0; cyc(2);

    // Continuous mode; the 2-bit counter of u_b wraps.
    on_ticks = 1; off_ticks = 1; cnt = 0;
    start = 1'b1; cyc();
    wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      cyc(2);
      chk("cont_bd_b",   32'(bd_b),   32'(wrap[i]));
      chk("cont_done_b", 32'(done_b), 32'd0);
    end
    start = 1'b0; cyc();

    // Stop during the second on-phase, then restart from OFF with on=5.
    on_ticks = 2; off_ticks = 2; cnt = 3;
    start = 1'b1; cyc();
    cyc(4);
    stop = 1'b1; cyc();
    chk("stop_led",  32'(led_a),  32'd0);
    chk("stop_bd",   32'(bd_a),   32'd1);
    chk("stop_busy", 32'(busy_a), 32'd0);
    stop = 1'b0; start = 1'b0; cyc();
    start = 1'b1; cyc();
    cyc(2);
    start = 1'b0; on_ticks = 5; cyc();
    start = 1'b1; cyc();
    chk("restart_bd", 32'(bd_a), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("restart_on", 32'(led_a), 32'd1);
      cyc();
    end
    chk("restart_off", 32'(led_a), 32'd0);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Reset mid-ON with start held high.
    start = 1'b0; cyc();
    start = 1'b1; cyc(2);
    rst = 1'b1; cyc();
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_bd",   32'(bd_a),   32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("no_restart", 32'(busy_a), 32'd0);
    end
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("restart_busy", 32'(busy_a), 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Active-low LED on u_b: on=2, off=2, one blink.
    on_ticks = 2; off_ticks = 2; cnt = 1;
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    pol = 5'b00111;
    for (int i = 0; i < 4; i++) begin
      chk("pol_led_b", 32'(led_b), 32'(pol[4-i]));
      cyc();
    end
    chk("pol_done_b", 32'(done_b), 32'd1);
    chk("pol_idle_b", 32'(led_b),  32'd1);
    cyc();
    chk("pol_hold_b", 32'(led_b),  32'd1);

    // Randomized stretch, including mid-sequence parameter changes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3, 0) == 0) start = ~start;
      stop = ($urandom_range(39, 0) == 0);
      rst  = ($urandom_range(149, 0) == 0);
      if ($urandom_range(7, 0) == 0) begin
        on_ticks  = CW'($urandom_range(5, 0));
        off_ticks = CW'($urandom_range(5, 0));
        cnt       = 4'($urandom_range(5, 0));
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
